// File: rtl/spi_burst_ctrl_if.sv
// SPI-side bundle between spi_burst_ctrl (master modport) and the SPI master core (slave modport).

interface spi_burst_ctrl_if #(
    parameter int unsigned BITS_SIZE = 8
);
    logic [BITS_SIZE-1:0] spi_data;
    logic                 spi_tx_start;
    logic                 spi_tx_done;
    logic                 spi_rx_done;
    logic [BITS_SIZE-1:0] spi_rx_data;

    modport master (
        output spi_data,
        output spi_tx_start,
        input  spi_tx_done,
        input  spi_rx_done,
        input  spi_rx_data
    );

    modport slave (
        input  spi_data,
        input  spi_tx_start,
        output spi_tx_done,
        output spi_rx_done,
        output spi_rx_data
    );
endinterface

// File: rtl/spi_burst_ctrl.sv
// Burst sequencer: drains a TX FIFO one frame at a time into an SPI master and collects
// received words into an RX FIFO. Optional WAIT-state watchdog under SPI_BURST_TIMEOUT_EN.

module spi_burst_ctrl #(
    parameter int unsigned BITS_SIZE = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 wr_en,
    input  logic [BITS_SIZE-1:0] wr_data,
    output logic                 tx_full,
    output logic [ADDR_W:0]      tx_count,

    input  logic                 go,

    input  logic                 rd_en,
    output logic [BITS_SIZE-1:0] rd_data,
    output logic                 rx_empty,
    output logic [ADDR_W:0]      rx_count,

    output logic                 busy,
    output logic                 burst_done,
    output logic                 overflow,
    output logic                 timeout,

    spi_burst_ctrl_if.master     spi
);

    localparam int unsigned CW = ADDR_W + 1;
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    if ((1 << ADDR_W) != DEPTH || DEPTH < 2 || TIMEOUT < 1) begin : g_param_err
        $error("spi_burst_ctrl: DEPTH must equal 2**ADDR_W (>=2) and TIMEOUT must be >= 1");
    end

    typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StDone} state_e;

    state_e               state_q, state_d;

    logic [BITS_SIZE-1:0] tx_mem [DEPTH];
    logic [BITS_SIZE-1:0] rx_mem [DEPTH];

    logic [ADDR_W-1:0]    tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [ADDR_W-1:0]    rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

    logic [BITS_SIZE-1:0] spi_data_q, spi_data_d;
    logic                 spi_tx_start_q, spi_tx_start_d;
    logic                 busy_q, busy_d;
    logic                 burst_done_q, burst_done_d;
    logic                 overflow_q, overflow_d;
    logic                 tx_seen_q, tx_seen_d;
    logic                 rx_seen_q, rx_seen_d;

    logic                 tx_push, tx_pop, tx_flush;
    logic                 rx_in, rx_push, rx_pop, rx_full, tx_empty;

`ifdef SPI_BURST_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]        wait_cnt_q, wait_cnt_d;
    logic                 timeout_q, timeout_d;
`endif

    assign tx_full  = (tx_cnt_q == FullCnt);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FullCnt);
    assign rx_empty = (rx_cnt_q == '0);
    assign tx_count = tx_cnt_q;
    assign rx_count = rx_cnt_q;

    // Gate the show-ahead head so stale storage never leaks out while empty.
    assign rd_data  = rx_empty ? '0 : rx_mem[rx_rd_ptr_q];

    assign spi.spi_data     = spi_data_q;
    assign spi.spi_tx_start = spi_tx_start_q;
    assign busy             = busy_q;
    assign burst_done       = burst_done_q;
    assign overflow         = overflow_q;

`ifdef SPI_BURST_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        spi_data_d = spi_data_q;
        tx_seen_d  = tx_seen_q;
        rx_seen_d  = rx_seen_q;
        tx_flush   = 1'b0;
`ifdef SPI_BURST_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (go && !tx_empty) state_d = StLoad;
            end
            StLoad: begin
                spi_data_d = tx_mem[tx_rd_ptr_q];
                state_d    = StStart;
            end
            StStart: begin
                tx_seen_d = 1'b0;
                rx_seen_d = 1'b0;
`ifdef SPI_BURST_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
                state_d   = StWait;
            end
            StWait: begin
                tx_seen_d = tx_seen_q | spi.spi_tx_done;
                rx_seen_d = rx_seen_q | spi.spi_rx_done;
                if (tx_seen_d && rx_seen_d) begin
                    state_d = tx_empty ? StDone : StLoad;
                end
`ifdef SPI_BURST_TIMEOUT_EN
                else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    tx_flush  = 1'b1;
                    state_d   = StDone;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
`endif
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        spi_tx_start_d = (state_d == StStart);
        busy_d         = (state_d != StIdle);
        burst_done_d   = (state_d == StDone);
    end

    // FIFO bookkeeping; at most one RX word is accepted per frame.
    always_comb begin
        tx_push = wr_en && !tx_full && !tx_flush;
        tx_pop  = (state_q == StLoad) && !tx_empty;
        rx_pop  = rd_en && !rx_empty;
        rx_in   = (state_q == StWait) && spi.spi_rx_done && !rx_seen_q;
        rx_push = rx_in && (!rx_full || rx_pop);

        overflow_d = overflow_q | (rx_in && rx_full && !rx_pop);

        tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + ADDR_W'(1) : tx_wr_ptr_q;
        tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + ADDR_W'(1) : tx_rd_ptr_q;
        tx_cnt_d    = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        if (tx_flush) begin
            tx_rd_ptr_d = tx_wr_ptr_q;
            tx_cnt_d    = '0;
        end

        rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + ADDR_W'(1) : rx_wr_ptr_q;
        rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + ADDR_W'(1) : rx_rd_ptr_q;
        rx_cnt_d    = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            tx_wr_ptr_q    <= '0;
            tx_rd_ptr_q    <= '0;
            tx_cnt_q       <= '0;
            rx_wr_ptr_q    <= '0;
            rx_rd_ptr_q    <= '0;
            rx_cnt_q       <= '0;
            spi_data_q     <= '0;
            spi_tx_start_q <= 1'b0;
            busy_q         <= 1'b0;
            burst_done_q   <= 1'b0;
            overflow_q     <= 1'b0;
            tx_seen_q      <= 1'b0;
            rx_seen_q      <= 1'b0;
`ifdef SPI_BURST_TIMEOUT_EN
            wait_cnt_q     <= '0;
            timeout_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            tx_wr_ptr_q    <= tx_wr_ptr_d;
            tx_rd_ptr_q    <= tx_rd_ptr_d;
            tx_cnt_q       <= tx_cnt_d;
            rx_wr_ptr_q    <= rx_wr_ptr_d;
            rx_rd_ptr_q    <= rx_rd_ptr_d;
            rx_cnt_q       <= rx_cnt_d;
            spi_data_q     <= spi_data_d;
            spi_tx_start_q <= spi_tx_start_d;
            busy_q         <= busy_d;
            burst_done_q   <= burst_done_d;
            overflow_q     <= overflow_d;
            tx_seen_q      <= tx_seen_d;
            rx_seen_q      <= rx_seen_d;
`ifdef SPI_BURST_TIMEOUT_EN
            wait_cnt_q     <= wait_cnt_d;
            timeout_q      <= timeout_d;
`endif
        end
    end

    // Storage needs no reset: occupancy counters decide what is valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr_q] <= wr_data;
        if (rx_push) rx_mem[rx_wr_ptr_q] <= spi.spi_rx_data;
    end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed self-checking bench for spi_burst_ctrl; the SPI master is modelled by hand-timed
// done pulses. The watchdog section runs only when SPI_BURST_TIMEOUT_EN is defined.

module tb_spi_burst_ctrl;

    localparam int unsigned BW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;
`ifdef SPI_BURST_TIMEOUT_EN
    localparam int unsigned TMO   = 16;
`else
    localparam int unsigned TMO   = 1024;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [BW-1:0] wr_data;
    logic          tx_full;
    logic [AW:0]   tx_count;
    logic          go;
    logic          rd_en;
    logic [BW-1:0] rd_data;
    logic          rx_empty;
    logic [AW:0]   rx_count;
    logic          busy;
    logic          burst_done;
    logic          overflow;
    logic          timeout;

    int total = 0;
    int bad   = 0;

    spi_burst_ctrl_if #(.BITS_SIZE(BW)) spi_if ();

    spi_burst_ctrl #(
        .BITS_SIZE(BW),
        .DEPTH    (DEPTH),
        .ADDR_W   (AW),
        .TIMEOUT  (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .tx_full   (tx_full),
        .tx_count  (tx_count),
        .go        (go),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rx_empty  (rx_empty),
        .rx_count  (rx_count),
        .busy      (busy),
        .burst_done(burst_done),
        .overflow  (overflow),
        .timeout   (timeout),
        .spi       (spi_if)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [BW-1:0] v);
        wr_en   = 1'b1;
        wr_data = v;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic pop(input logic [BW-1:0] exp);
        chk("rd_data", rd_data, exp);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    // Returns at the cycle spi_tx_start is seen; gap counts cycles from the call.
    task automatic wait_start(input logic [BW-1:0] exp, input int exp_gap);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            go = 1'b0;
            n++;
            if (spi_if.spi_tx_start === 1'b1) seen = 1'b1;
        end
        chk("start_gap", n, exp_gap);
        chk("spi_data", spi_if.spi_data, exp);
        chk("busy_in_frame", busy, 1);
        chk("no_early_burst_done", burst_done, 0);
    endtask

    // Delays count WAIT cycles (>=1); returns in the cycle after the later done.
    task automatic finish_frame(input logic [BW-1:0] rxv, input int tx_dly, input int rx_dly,
                                input bit do_wr, input logic [BW-1:0] wv, input int exp_rx);
        int maxd = (tx_dly > rx_dly) ? tx_dly : rx_dly;
        spi_if.spi_rx_data = rxv;
        for (int i = 0; i <= maxd; i++) begin
            spi_if.spi_tx_done = (i == tx_dly);
            spi_if.spi_rx_done = (i == rx_dly);
            wr_en   = do_wr && (i == 0);
            wr_data = wv;
            @(negedge clk);
            chk("start_single_cycle", spi_if.spi_tx_start, 0);
        end
        spi_if.spi_tx_done = 1'b0;
        spi_if.spi_rx_done = 1'b0;
        wr_en = 1'b0;
        chk("rx_count_after_frame", rx_count, exp_rx);
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0;
        wr_data = '0;
        go = 1'b0;
        rd_en = 1'b0;
        spi_if.spi_tx_done = 1'b0;
        spi_if.spi_rx_done = 1'b0;
        spi_if.spi_rx_data = '0;
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        chk("rst_tx_count", tx_count, 0);
        chk("rst_rx_count", rx_count, 0);
        chk("rst_rx_empty", rx_empty, 1);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_spi_data", spi_if.spi_data, 0);
        chk("rst_tx_start", spi_if.spi_tx_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_burst_done", burst_done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_rd_data", rd_data, 0);

        // go with an empty TX FIFO is ignored
        go = 1'b1;
        step();
        go = 1'b0;
        step();
        chk("go_empty_ignored", busy, 0);

        // Single word, slave echo
        wr(8'hA5);
        chk("tx_count_one", tx_count, 1);
        go = 1'b1;
        wait_start(8'hA5, 2);
        finish_frame(8'hA5, 4, 4, 1'b0, 8'h00, 1);
        chk("single_burst_done", burst_done, 1);
        chk("single_rx_empty", rx_empty, 0);
        step();
        chk("single_done_pulse", burst_done, 0);
        chk("single_busy_low", busy, 0);
        pop(8'hA5);
        chk("single_rx_drained", rx_empty, 1);

        // Three words plus one written mid-burst; mixed done orderings
        wr(8'h01);
        wr(8'h02);
        wr(8'h03);
        go = 1'b1;
        wait_start(8'h01, 2);
        finish_frame(8'h11, 2, 2, 1'b1, 8'h04, 1);
        wait_start(8'h02, 1);
        finish_frame(8'h22, 4, 1, 1'b0, 8'h00, 2);
        wait_start(8'h03, 1);
        finish_frame(8'h33, 1, 1, 1'b0, 8'h00, 3);
        wait_start(8'h04, 1);
        finish_frame(8'h44, 1, 5, 1'b0, 8'h00, 4);
        chk("multi_burst_done", burst_done, 1);
        step();
        chk("multi_done_pulse", burst_done, 0);
        chk("multi_busy_low", busy, 0);
        pop(8'h11);
        pop(8'h22);
        pop(8'h33);
        pop(8'h44);

        // Fill TX, drop the ninth write, then overflow RX
        for (int k = 0; k < 8; k++) wr(8'h80 + 8'(k));
        chk("fill_tx_full", tx_full, 1);
        chk("fill_tx_count", tx_count, 8);
        wr(8'h88);
        chk("fill_drop_count", tx_count, 8);
        go = 1'b1;
        wait_start(8'h80, 2);
        finish_frame(8'h80, 1, 1, 1'b0, 8'h00, 1);
        for (int k = 1; k < 8; k++) begin
            wait_start(8'h80 + 8'(k), 1);
            finish_frame(8'h80 + 8'(k), 1, 1, 1'b0, 8'h00, k + 1);
        end
        chk("fill_burst_done", burst_done, 1);
        chk("fill_no_overflow", overflow, 0);
        step();
        wr(8'h99);
        go = 1'b1;
        wait_start(8'h99, 2);
        finish_frame(8'h99, 1, 1, 1'b0, 8'h00, 8);
        chk("overflow_set", overflow, 1);
        step();
        for (int k = 0; k < 8; k++) pop(8'h80 + 8'(k));
        chk("overflow_drained", rx_empty, 1);
        chk("overflow_sticky", overflow, 1);

        // Reset mid-burst with 3 words still queued
        for (int k = 0; k < 5; k++) wr(8'hC0 + 8'(k));
        go = 1'b1;
        wait_start(8'hC0, 2);
        finish_frame(8'h5A, 1, 1, 1'b0, 8'h00, 1);
        wait_start(8'hC1, 1);
        step();
        chk("pre_reset_tx_count", tx_count, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tx_count", tx_count, 0);
        chk("mid_rst_rx_count", rx_count, 0);
        chk("mid_rst_tx_start", spi_if.spi_tx_start, 0);
        chk("mid_rst_burst_done", burst_done, 0);
        chk("mid_rst_overflow", overflow, 0);
        step();
        chk("post_rst_burst_done", burst_done, 0);
        chk("post_rst_busy", busy, 0);

`ifdef SPI_BURST_TIMEOUT_EN
        // Hold both done lines low: 16 WAIT cycles then DONE with timeout set
        wr(8'hD0);
        wr(8'hD1);
        go = 1'b1;
        wait_start(8'hD0, 2);
        repeat (16) step();
        chk("tmo_not_yet", timeout, 0);
        chk("tmo_still_busy", busy, 1);
        step();
        chk("tmo_set", timeout, 1);
        chk("tmo_burst_done", burst_done, 1);
        chk("tmo_flushed", tx_count, 0);
        step();
        chk("tmo_idle", busy, 0);
        chk("tmo_sticky", timeout, 1);
`else
        chk("timeout_tied_low", timeout, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_burst_ctrl.md
# spi_burst_ctrl

Byte-burst sequencer sitting directly upstream of the SPI master/slave pair. Host logic loads transmit words into a TX FIFO, then issues a single `go`. The block feeds one word per frame to the master's `data_in`, pulses `tx_start`, waits for that frame's `tx_done`/`rx_done`, and pushes each received master word into an RX FIFO. It repeats until the TX FIFO is empty, so multi-word SPI transfers run without per-word host handshaking.

## Interface
Parameters:
- `BITS_SIZE`, 8, word width; must match the SPI master's `bits_size`
- `DEPTH`, 8, entries per FIFO; power of two, ≥2
- `ADDR_W`, 3, log2(DEPTH)
- `TIMEOUT`, 1024, WAIT-state cycle limit; used only under `SPI_BURST_TIMEOUT_EN`

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: sole clock, rising edge
- `reset` in 1: synchronous, active-high
- `wr_en` in 1: push `wr_data` into the TX FIFO; ignored when `tx_full`
- `wr_data` in BITS_SIZE: TX word
- `tx_full` out 1: TX FIFO full
- `tx_count` out ADDR_W+1: TX FIFO occupancy
- `go` in 1: start a burst; honoured only in IDLE with TX FIFO non-empty
- `rd_en` in 1: pop the RX FIFO; ignored when `rx_empty`
- `rd_data` out BITS_SIZE: RX FIFO head (show-ahead), valid while `!rx_empty`
- `rx_empty` out 1: RX FIFO empty
- `rx_count` out ADDR_W+1: RX FIFO occupancy
- `busy` out 1: state ≠ IDLE
- `burst_done` out 1: one-cycle pulse at burst end
- `overflow` out 1: sticky; an RX word was dropped because the FIFO was full
- `timeout` out 1: sticky; WAIT-state limit hit (constant 0 without the macro)
- `spi_data` out BITS_SIZE: to master `data_in`
- `spi_tx_start` out 1: to master `tx_start`
- `spi_tx_done` in 1: from master `tx_done`
- `spi_rx_done` in 1: from master `rx_done`
- `spi_rx_data` in BITS_SIZE: from master `data_out`

## Operation
- FSM states: IDLE, LOAD, START, WAIT, DONE.
- **IDLE:** on `go && tx_count != 0`, go to LOAD. Otherwise, `go` is ignored.
- **LOAD:** pop the TX FIFO head into the `spi_data` register. Go to START.
- **START:** `spi_tx_start` = 1 for exactly this one cycle. Clear the `tx_seen` and `rx_seen` flags. Go to WAIT.
- **WAIT:**
  - On `spi_tx_done`, set `tx_seen`. On `spi_rx_done`, set `rx_seen` and push `spi_rx_data` into the RX FIFO.
  - The two done signals may arrive in the same cycle or in any order.
  - When both flags are set (including same-cycle arrival), go to LOAD if the TX FIFO is non-empty, else go to DONE.
- **DONE:** `burst_done` = 1 for one cycle. Go to IDLE.
- `spi_data` is held stable from LOAD until the next LOAD.
- `wr_en` is accepted in every state. A word written before the WAIT exit decision is included in the current burst.
- **RX push when full:** the word is dropped and `overflow` is set, unless `rd_en` is asserted in the same cycle, in which case the push succeeds.
- Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Pointers are ADDR_W bits wide and wrap modulo DEPTH. Counts are ADDR_W+1 bits and saturate at neither end, because guards prevent overflow and underflow.
- `overflow` and `timeout` clear only on `reset`.

## Timing
- **Reset values:** state IDLE; both FIFOs empty; `tx_count` = `rx_count` = 0; `rx_empty` = 1; `tx_full` = 0; `spi_data` = 0; `spi_tx_start` = 0; `busy` = 0; `burst_done` = 0; `overflow` = 0; `timeout` = 0; `rd_data` = 0.
- **Start latency:** with `go` sampled at edge N, LOAD occupies cycle N+1, `spi_tx_start` is high in cycle N+2, and `busy` is high from N+1.
- **Inter-word gap:** from the cycle both done flags are set, `spi_tx_start` rises again exactly 2 cycles later (LOAD, then START).
- **RX visibility:** with `spi_rx_done` sampled at edge M, `rx_empty` falls and `rx_count` increments in cycle M+1.
- **FIFO flags:** `tx_full` and `tx_count` update one cycle after `wr_en` or the LOAD pop.
- **Reset mid-burst:** returns to IDLE on the next edge, flushes both FIFOs, and drives `spi_tx_start` low. The SPI pair shares `reset` and aborts with it.

## Configuration
- `SPI_BURST_TIMEOUT_EN` defined:
  - A counter runs in WAIT, clearing on entry.
  - If it reaches TIMEOUT with either done flag still clear, set `timeout`, flush the remaining TX FIFO words, and go to DONE. `burst_done` still pulses.
- `SPI_BURST_TIMEOUT_EN` undefined:
  - No counter is built and WAIT has no time limit.
  - `timeout` is tied to 0.

## Test plan
- Reset, write 0xA5, then pulse `go` → `spi_tx_start` high exactly 2 cycles after `go` with `spi_data` = 0xA5. After the master completes, `rd_data` = 0xA5 (slave echo). `burst_done` pulses once, then `busy` = 0.
- Write 0x01, 0x02, 0x03, pulse `go`, and write 0x04 mid-burst → four frames sent in order 01, 02, 03, 04. `rx_count` = 4 and one `burst_done`.
- Write 8 words to fill the FIFO, then a 9th → `tx_full` = 1, `tx_count` = 8, and the 9th word is dropped. Write 9 words without reading RX → `overflow` = 1 and `rx_count` = 8.
- Drive `spi_rx_done` 3 cycles before `spi_tx_done`, and in another frame in the same cycle → exactly one RX push per frame, and the next `spi_tx_start` comes 2 cycles after the later done.
- Assert `reset` for one cycle while in WAIT with 3 words queued → next cycle: IDLE, `tx_count` = 0, `rx_count` = 0, `spi_tx_start` = 0, no `burst_done`.
- With `SPI_BURST_TIMEOUT_EN` and TIMEOUT = 16, hold `spi_tx_done` low → `timeout` = 1 after 16 WAIT cycles, `burst_done` pulses, `tx_count` = 0.
